// File: rtl/lfsr_pkg.sv
// Shared types and sizing for the LFSR period sequencer and its step divider.
package lfsr_pkg;

  localparam int LFSR_BITS   = 5;
  localparam int PERIOD_BITS = LFSR_BITS + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TAPS,
    LOAD_SEED,
    RUN,
    CHECK,
    DONE
  } seq_state_e;

endpackage

// File: rtl/step_divider.sv
// Step-interval counter: after start, tick is a registered pulse in the STEP_DIV-th run cycle.
module step_divider #(
  parameter int STEP_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic tick
);

  localparam int            CW         = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] PRE_TERM   = (STEP_DIV > 1) ? CW'(STEP_DIV - 2) : '0;
  localparam logic          FIRST_TICK = (STEP_DIV == 1);

  logic [CW-1:0] cnt;

  // tick is decided one cycle early so it can leave a flop directly.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      tick <= FIRST_TICK;
    end else if (run && !tick) begin
      cnt  <= cnt + CW'(1);
      tick <= (cnt == PRE_TERM);
    end else begin
      cnt  <= '0;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_period_sequencer.sv
// Programs an external Galois LFSR core, steps it at a divided rate and measures
// how many steps it takes for the core state to come back to the seed.
module lfsr_period_sequencer
  import lfsr_pkg::*;
#(
  parameter int LFSR_BITS = lfsr_pkg::LFSR_BITS,
  parameter int STEP_DIV  = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LFSR_BITS-1:0] cmd_taps,
  input  logic [LFSR_BITS-1:0] cmd_seed,
  input  logic                 abort,
  output logic [LFSR_BITS-1:0] lfsr_data,
  output logic                 lfsr_load_taps,
  output logic                 lfsr_load_seed,
  output logic                 lfsr_step,
  input  logic [LFSR_BITS-1:0] lfsr_state,
  output logic                 busy,
  output logic                 done,
  output logic [LFSR_BITS:0]   period,
  output logic                 no_return
);

  localparam int            PW        = LFSR_BITS + 1;
  localparam logic [PW-1:0] MAX_STEPS = PW'(2 ** LFSR_BITS);

  seq_state_e           state;
  logic [LFSR_BITS-1:0] seed_q;
  logic [PW-1:0]        count;
  logic [PW-1:0]        count_next;
  logic                 returned;
  logic                 exhausted;
  logic                 div_start;
  logic                 div_run;

  assign count_next = count + PW'(1);
  assign returned   = (lfsr_state == seed_q);
  assign exhausted  = (count_next == MAX_STEPS);
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

  // A fresh step interval begins on entry to RUN; abort must not leave a step pending.
  assign div_start = !abort && ((state == LOAD_SEED) ||
                                (state == CHECK && !returned && !exhausted));
  assign div_run   = !abort && (state == RUN);

  step_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_step_divider (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .run   (div_run),
    .tick  (lfsr_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      seed_q         <= '0;
      count          <= '0;
      period         <= '0;
      no_return      <= 1'b0;
      done           <= 1'b0;
      lfsr_data      <= '0;
      lfsr_load_taps <= 1'b0;
      lfsr_load_seed <= 1'b0;
    end else begin
      done           <= 1'b0;
      lfsr_load_taps <= 1'b0;
      lfsr_load_seed <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              seed_q         <= cmd_seed;
              period         <= '0;
              no_return      <= 1'b0;
              lfsr_data      <= cmd_taps;
              lfsr_load_taps <= 1'b1;
              state          <= LOAD_TAPS;
            end
          end
          LOAD_TAPS: begin
            lfsr_data      <= seed_q;
            lfsr_load_seed <= 1'b1;
            state          <= LOAD_SEED;
          end
          LOAD_SEED: begin
            count <= '0;
            state <= RUN;
          end
          RUN: begin
            if (lfsr_step) state <= CHECK;
          end
          CHECK: begin
            // The core state seen here already includes the step taken in RUN.
            if (returned) begin
              period <= count_next;
              done   <= 1'b1;
              state  <= DONE;
            end else if (exhausted) begin
              period    <= count_next;
              no_return <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              count <= count_next;
              state <= RUN;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_period_sequencer.sv
// Directed bench: two sequencers (STEP_DIV=1 and STEP_DIV=4), each driving its own LFSR core model.
module tb_lfsr_period_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // STEP_DIV = 1 instance
  logic       reset = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [4:0] cmd_taps = '0, cmd_seed = '0;
  logic       cmd_ready, lfsr_load_taps, lfsr_load_seed, lfsr_step, busy, done, no_return;
  logic [4:0] lfsr_data, lfsr_state;
  logic [5:0] period;

  // STEP_DIV = 4 instance
  logic       reset_4 = 1'b1, cmd_valid_4 = 1'b0, abort_4 = 1'b0;
  logic [4:0] cmd_taps_4 = '0, cmd_seed_4 = '0;
  logic       cmd_ready_4, lfsr_load_taps_4, lfsr_load_seed_4, lfsr_step_4, busy_4, done_4, no_return_4;
  logic [4:0] lfsr_data_4, lfsr_state_4;
  logic [5:0] period_4;

  lfsr_period_sequencer #(.LFSR_BITS(5), .STEP_DIV(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_taps(cmd_taps), .cmd_seed(cmd_seed), .abort(abort), .lfsr_data(lfsr_data),
    .lfsr_load_taps(lfsr_load_taps), .lfsr_load_seed(lfsr_load_seed), .lfsr_step(lfsr_step),
    .lfsr_state(lfsr_state), .busy(busy), .done(done), .period(period), .no_return(no_return)
  );

  lfsr_period_sequencer #(.LFSR_BITS(5), .STEP_DIV(4)) dut4 (
    .clk(clk), .reset(reset_4), .cmd_valid(cmd_valid_4), .cmd_ready(cmd_ready_4),
    .cmd_taps(cmd_taps_4), .cmd_seed(cmd_seed_4), .abort(abort_4), .lfsr_data(lfsr_data_4),
    .lfsr_load_taps(lfsr_load_taps_4), .lfsr_load_seed(lfsr_load_seed_4), .lfsr_step(lfsr_step_4),
    .lfsr_state(lfsr_state_4), .busy(busy_4), .done(done_4), .period(period_4), .no_return(no_return_4)
  );

  function automatic logic [4:0] galois(input logic [4:0] s, input logic [4:0] t);
    return s[0] ? ((s >> 1) ^ t) : (s >> 1);
  endfunction

  // LFSR core models: not reset, only the sequencer strobes change them.
  logic [4:0] core_taps = '0, core_state = '0, core_taps_4 = '0, core_state_4 = '0;
  assign lfsr_state   = core_state;
  assign lfsr_state_4 = core_state_4;

  always @(posedge clk) begin
    if (lfsr_load_taps)      core_taps  <= lfsr_data;
    else if (lfsr_load_seed) core_state <= lfsr_data;
    else if (lfsr_step)      core_state <= galois(core_state, core_taps);
    if (lfsr_load_taps_4)      core_taps_4  <= lfsr_data_4;
    else if (lfsr_load_seed_4) core_state_4 <= lfsr_data_4;
    else if (lfsr_step_4)      core_state_4 <= galois(core_state_4, core_taps_4);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Issues one command on the STEP_DIV=1 instance (handshake = cycle 0) and follows it to done.
  task automatic run_cmd(input logic [4:0] t, input logic [4:0] s, input int limit,
                         output logic ready0, output int done_cyc, output int steps,
                         output int taps_cyc, output int seed_cyc, output int multi);
    @(negedge clk);
    ready0    = cmd_ready;
    cmd_taps  = t;
    cmd_seed  = s;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    done_cyc = -1; steps = 0; taps_cyc = -1; seed_cyc = -1; multi = 0;
    for (int c = 1; c <= limit; c++) begin
      if (lfsr_step) steps++;
      if (lfsr_load_taps && taps_cyc < 0) taps_cyc = c;
      if (lfsr_load_seed && seed_cyc < 0) seed_cyc = c;
      if (int'(lfsr_step) + int'(lfsr_load_taps) + int'(lfsr_load_seed) > 1) multi++;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_handshake: ready=%0b busy=%0b expected ready=1 busy=0", cmd_ready, busy); end
    n_checks++; if (done !== 1'b0 || period !== 6'd0 || no_return !== 1'b0) begin n_fail++;
      $display("FAIL reset_result: done=%0b period=%0d no_return=%0b expected 0/0/0", done, period, no_return); end
    n_checks++; if ({lfsr_load_taps, lfsr_load_seed, lfsr_step} !== 3'b000 || lfsr_data !== 5'd0) begin n_fail++;
      $display("FAIL reset_strobes: strobes=%b data=%0d expected 000/0",
               {lfsr_load_taps, lfsr_load_seed, lfsr_step}, lfsr_data); end
    reset   = 1'b0;
    reset_4 = 1'b0;
  endtask

  task automatic test_maximal();
    logic r0; int dc, st, tc, sc, mu;
    run_cmd(5'b10100, 5'd1, 100, r0, dc, st, tc, sc, mu);
    n_checks++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL max_ready: got %0b expected 1", r0); end
    n_checks++; if (tc !== 1 || sc !== 2) begin n_fail++;
      $display("FAIL max_load_cycles: taps@%0d seed@%0d expected 1/2", tc, sc); end
    n_checks++; if (dc !== 65) begin n_fail++; $display("FAIL max_done_cycle: got %0d expected 65", dc); end
    n_checks++; if (st !== 31) begin n_fail++; $display("FAIL max_step_count: got %0d expected 31", st); end
    n_checks++; if (period !== 6'd31 || no_return !== 1'b0) begin n_fail++;
      $display("FAIL max_result: period=%0d no_return=%0b expected 31/0", period, no_return); end
    n_checks++; if (mu !== 0) begin n_fail++; $display("FAIL max_strobe_exclusive: %0d overlaps expected 0", mu); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || period !== 6'd31) begin n_fail++;
      $display("FAIL max_after_done: done=%0b ready=%0b period=%0d expected 0/1/31", done, cmd_ready, period); end
  endtask

  task automatic test_zero_seed();
    logic r0; int dc, st, tc, sc, mu;
    run_cmd(5'b10100, 5'd0, 20, r0, dc, st, tc, sc, mu);
    n_checks++; if (dc !== 5 || st !== 1) begin n_fail++;
      $display("FAIL zero_seed_timing: done@%0d steps=%0d expected 5/1", dc, st); end
    n_checks++; if (period !== 6'd1 || no_return !== 1'b0) begin n_fail++;
      $display("FAIL zero_seed_result: period=%0d no_return=%0b expected 1/0", period, no_return); end
  endtask

  task automatic test_no_return();
    logic r0; int dc, st, tc, sc, mu;
    run_cmd(5'b00000, 5'd1, 100, r0, dc, st, tc, sc, mu);
    n_checks++; if (dc !== 67 || st !== 32) begin n_fail++;
      $display("FAIL no_return_timing: done@%0d steps=%0d expected 67/32", dc, st); end
    n_checks++; if (period !== 6'd32 || no_return !== 1'b1) begin n_fail++;
      $display("FAIL no_return_result: period=%0d no_return=%0b expected 32/1", period, no_return); end
  endtask

  task automatic test_back_to_back();
    logic r0; int dc, st, tc, sc, mu, first_done;
    @(negedge clk);
    cmd_taps = 5'b10100; cmd_seed = 5'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if (period !== 6'd0 || no_return !== 1'b0) begin n_fail++;
      $display("FAIL accept_clears_result: period=%0d no_return=%0b expected 0/0", period, no_return); end
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL busy_ready: ready=%0b busy=%0b expected 0/1", cmd_ready, busy); end
    cmd_taps = 5'd0; cmd_seed = 5'd0; cmd_valid = 1'b1;
    first_done = -1;
    for (int c = 3; c <= 100; c++) begin
      if (c == 6) cmd_valid = 1'b0;
      if (done) begin
        first_done = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (first_done !== 65 || period !== 6'd31 || no_return !== 1'b0) begin n_fail++;
      $display("FAIL ignored_cmd: done@%0d period=%0d no_return=%0b expected 65/31/0", first_done, period, no_return); end
    run_cmd(5'b10100, 5'd1, 100, r0, dc, st, tc, sc, mu);
    n_checks++; if (r0 !== 1'b1 || dc !== 65 || st !== 31 || period !== 6'd31) begin n_fail++;
      $display("FAIL reissue: ready=%0b done@%0d steps=%0d period=%0d expected 1/65/31/31", r0, dc, st, period); end
  endtask

  task automatic test_abort();
    logic r0; int dc, st, tc, sc, mu; logic saw_done;
    @(negedge clk);
    cmd_taps = 5'b10100; cmd_seed = 5'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL abort_idle: busy=%0b ready=%0b expected 0/1", busy, cmd_ready); end
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      saw_done |= done | lfsr_step;
      @(negedge clk);
    end
    n_checks++; if (saw_done !== 1'b0 || period !== 6'd0 || no_return !== 1'b0) begin n_fail++;
      $display("FAIL abort_quiet: done_or_step=%0b period=%0d no_return=%0b expected 0/0/0", saw_done, period, no_return); end
    run_cmd(5'b10100, 5'd0, 20, r0, dc, st, tc, sc, mu);
    n_checks++; if (dc !== 5 || period !== 6'd1) begin n_fail++;
      $display("FAIL abort_recover: done@%0d period=%0d expected 5/1", dc, period); end
  endtask

  task automatic test_div4_reset();
    int q[$];
    int exp_q[5] = '{1, 2, 6, 11, 16};
    int dc;
    @(negedge clk);
    cmd_taps_4 = 5'b10100; cmd_seed_4 = 5'd1; cmd_valid_4 = 1'b1;
    @(negedge clk);
    cmd_valid_4 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (lfsr_load_taps_4 || lfsr_load_seed_4 || lfsr_step_4) q.push_back(c);
      @(negedge clk);
    end
    n_checks++; if (q.size() !== 5) begin n_fail++;
      $display("FAIL div4_strobe_count: got %0d expected 5", q.size()); end
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      n_checks++; if (q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL div4_strobe_cycle[%0d]: got %0d expected %0d", i, q[i], exp_q[i]); end
    end
    n_checks++; if (busy_4 !== 1'b1) begin n_fail++; $display("FAIL div4_busy_run: got %0b expected 1", busy_4); end
    reset_4 = 1'b1;
    @(negedge clk);
    n_checks++; if (busy_4 !== 1'b0 || cmd_ready_4 !== 1'b1 || done_4 !== 1'b0) begin n_fail++;
      $display("FAIL midrun_reset_fsm: busy=%0b ready=%0b done=%0b expected 0/1/0", busy_4, cmd_ready_4, done_4); end
    n_checks++; if ({lfsr_load_taps_4, lfsr_load_seed_4, lfsr_step_4} !== 3'b000 || lfsr_data_4 !== 5'd0
                    || period_4 !== 6'd0 || no_return_4 !== 1'b0) begin n_fail++;
      $display("FAIL midrun_reset_outputs: strobes=%b data=%0d period=%0d no_return=%0b expected 000/0/0/0",
               {lfsr_load_taps_4, lfsr_load_seed_4, lfsr_step_4}, lfsr_data_4, period_4, no_return_4); end
    @(negedge clk);
    reset_4 = 1'b0;
    @(negedge clk);
    cmd_taps_4 = 5'b10100; cmd_seed_4 = 5'd0; cmd_valid_4 = 1'b1;
    @(negedge clk);
    cmd_valid_4 = 1'b0;
    dc = -1;
    for (int c = 1; c <= 30; c++) begin
      if (done_4) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (dc !== 8 || period_4 !== 6'd1 || no_return_4 !== 1'b0) begin n_fail++;
      $display("FAIL div4_after_reset: done@%0d period=%0d no_return=%0b expected 8/1/0", dc, period_4, no_return_4); end
  endtask

  initial begin
    test_reset();
    test_maximal();
    test_zero_seed();
    test_no_return();
    test_back_to_back();
    test_abort();
    test_div4_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
